// File: rtl/p448_accum_pkg.sv
// Shared constants, state encoding and helpers for the p448 column
// accumulator. Every width in the accumulator datapath comes from here.
package p448_accum_pkg;

  // Ceiling log2. Returns 0 for an argument of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int PROD_W    = 64;
  localparam int LIMB_W    = 28;
  localparam int ACC_W     = 80;
  localparam int MAX_TERMS = 256;
  localparam int COL_IDX_W = 5;
  localparam int CARRY_W   = ACC_W - LIMB_W;
  // One extra bit so the count can reach MAX_TERMS itself and still
  // expose the "one term too many" case.
  localparam int TERM_W    = clog2(MAX_TERMS) + 1;

  typedef enum logic {
    ACC  = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/p448_limb_out_reg.sv
// Output register for the column accumulator.
// Captures one result limb (with its column index, frame-last flag and
// final carry) on load, and holds it stable with m_valid high until the
// downstream accepts it.
//   clk, rst_n         : clock, asynchronous active-low reset
//   load               : capture ld_* this cycle (only issued while empty)
//   ld_*               : limb fields to capture
//   m_ready            : downstream accept
//   m_valid/m_*        : registered limb output
//   xfer               : limb transfers this cycle (m_valid && m_ready)
module p448_limb_out_reg
  import p448_accum_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [LIMB_W-1:0]    ld_limb,
  input  logic [COL_IDX_W-1:0] ld_col_idx,
  input  logic                 ld_frame_last,
  input  logic [CARRY_W-1:0]   ld_carry,
  input  logic                 m_ready,
  output logic                 m_valid,
  output logic [LIMB_W-1:0]    m_limb,
  output logic [COL_IDX_W-1:0] m_col_idx,
  output logic                 m_frame_last,
  output logic [CARRY_W-1:0]   m_carry,
  output logic                 xfer
);

  logic                 valid_q, valid_d;
  logic [LIMB_W-1:0]    limb_q, limb_d;
  logic [COL_IDX_W-1:0] col_idx_q, col_idx_d;
  logic                 frame_last_q, frame_last_d;
  logic [CARRY_W-1:0]   carry_q, carry_d;

  assign xfer = valid_q && m_ready;

  always_comb begin
    valid_d      = valid_q;
    limb_d       = limb_q;
    col_idx_d    = col_idx_q;
    frame_last_d = frame_last_q;
    carry_d      = carry_q;
    if (load) begin
      valid_d      = 1'b1;
      limb_d       = ld_limb;
      col_idx_d    = ld_col_idx;
      frame_last_d = ld_frame_last;
      carry_d      = ld_carry;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  // ---- output register stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      limb_q       <= '0;
      col_idx_q    <= '0;
      frame_last_q <= 1'b0;
      carry_q      <= '0;
    end else begin
      valid_q      <= valid_d;
      limb_q       <= limb_d;
      col_idx_q    <= col_idx_d;
      frame_last_q <= frame_last_d;
      carry_q      <= carry_d;
    end
  end

  assign m_valid      = valid_q;
  assign m_limb       = limb_q;
  assign m_col_idx    = col_idx_q;
  assign m_frame_last = frame_last_q;
  assign m_carry      = carry_q;

endmodule

// File: rtl/p448_col_accum_carry.sv
// Streaming column accumulator / carry propagator for the p448 carry_mul
// datapath. Sums the partial products of one limb column, adds the carry
// from the previous column, emits the low LIMB_W bits as the column limb
// and carries the rest forward. The last column of a frame also emits the
// remaining carry and the running carry restarts at zero.
//   ap_clk, ap_rst_n           : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data     : partial-product input stream
//   s_col_last, s_frame_last   : column / frame delimiters on the beat
//   m_valid/m_ready            : limb output handshake
//   m_limb, m_col_idx          : column result limb and its index
//   m_frame_last, m_carry      : frame end marker and final carry
//   ovf                        : sticky overflow (adder carry-out or
//                                too many terms in a column)
module p448_col_accum_carry
  import p448_accum_pkg::*;
(
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [PROD_W-1:0]    s_data,
  input  logic                 s_col_last,
  input  logic                 s_frame_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [LIMB_W-1:0]    m_limb,
  output logic [COL_IDX_W-1:0] m_col_idx,
  output logic                 m_frame_last,
  output logic [CARRY_W-1:0]   m_carry,
  output logic                 ovf
);

  localparam logic [TERM_W-1:0] TERM_LIMIT = TERM_W'(MAX_TERMS);

  // Term counter saturates at all-ones so a runaway column cannot wrap
  // back under the limit and hide the overflow.
  function automatic logic [TERM_W-1:0] term_inc_sat(input logic [TERM_W-1:0] t);
    if (&t) return t;
    return t + TERM_W'(1);
  endfunction

  state_e               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CARRY_W-1:0]   carry_q, carry_d;
  logic [COL_IDX_W-1:0] col_idx_q, col_idx_d;
  logic [TERM_W-1:0]    term_cnt_q, term_cnt_d;
  logic                 ovf_q, ovf_d;

  logic                 beat;
  logic [ACC_W:0]       part_sum;   // acc + product, with carry-out bit
  logic [ACC_W+1:0]     close_sum;  // acc + product + column carry
  logic                 out_load;
  logic [LIMB_W-1:0]    out_limb;
  logic [COL_IDX_W-1:0] out_col_idx;
  logic                 out_frame_last;
  logic [CARRY_W-1:0]   out_carry;
  logic                 out_xfer;

  // Ready depends on state only, so there is no combinational path from
  // m_ready back to s_ready.
  assign s_ready = (state_q == ACC);
  assign beat    = s_valid && s_ready;

  always_comb begin
    acc_d          = acc_q;
    carry_d        = carry_q;
    col_idx_d      = col_idx_q;
    term_cnt_d     = term_cnt_q;
    ovf_d          = ovf_q;
    state_d        = state_q;
    out_load       = 1'b0;
    out_limb       = '0;
    out_col_idx    = '0;
    out_frame_last = 1'b0;
    out_carry      = '0;

    part_sum  = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, s_data};
    close_sum = {1'b0, part_sum} + {{(ACC_W + 2 - CARRY_W){1'b0}}, carry_q};

    case (state_q)
      ACC: begin
        if (beat) begin
          // term_cnt counts terms already in the column; this beat is
          // term number term_cnt+1.
          if (term_cnt_q >= TERM_LIMIT) ovf_d = 1'b1;
          if (!s_col_last) begin
            acc_d      = part_sum[ACC_W-1:0];
            term_cnt_d = term_inc_sat(term_cnt_q);
            if (part_sum[ACC_W]) ovf_d = 1'b1;
          end else begin
            if (close_sum[ACC_W+1:ACC_W] != 2'b00) ovf_d = 1'b1;
            out_load    = 1'b1;
            out_limb    = close_sum[LIMB_W-1:0];
            out_col_idx = col_idx_q;
            acc_d       = '0;
            term_cnt_d  = '0;
            state_d     = EMIT;
            if (s_frame_last) begin
              out_frame_last = 1'b1;
              out_carry      = close_sum[ACC_W-1:LIMB_W];
              carry_d        = '0;
              col_idx_d      = '0;
            end else begin
              carry_d   = close_sum[ACC_W-1:LIMB_W];
              col_idx_d = col_idx_q + COL_IDX_W'(1);
            end
          end
        end
      end
      EMIT: begin
        if (out_xfer) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  // ---- accumulate stage ----
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= ACC;
      acc_q      <= '0;
      carry_q    <= '0;
      col_idx_q  <= '0;
      term_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      col_idx_q  <= col_idx_d;
      term_cnt_q <= term_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ovf = ovf_q;

  p448_limb_out_reg u_out (
    .clk          (ap_clk),
    .rst_n        (ap_rst_n),
    .load         (out_load),
    .ld_limb      (out_limb),
    .ld_col_idx   (out_col_idx),
    .ld_frame_last(out_frame_last),
    .ld_carry     (out_carry),
    .m_ready      (m_ready),
    .m_valid      (m_valid),
    .m_limb       (m_limb),
    .m_col_idx    (m_col_idx),
    .m_frame_last (m_frame_last),
    .m_carry      (m_carry),
    .xfer         (out_xfer)
  );

endmodule

// File: tb/tb_p448_col_accum_carry.sv
module tb_p448_col_accum_carry;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        s_col_last;
  logic        s_frame_last;
  logic        m_valid;
  logic        m_ready;
  logic [27:0] m_limb;
  logic [4:0]  m_col_idx;
  logic        m_frame_last;
  logic [51:0] m_carry;
  logic        ovf;

  int vectors;
  int miscompares;
  int xfer_cnt;

  typedef struct packed {
    logic [27:0] limb;
    logic [4:0]  idx;
    logic        fl;
    logic [51:0] carry;
  } rec_t;
  rec_t recs[$];

  p448_col_accum_carry dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_col_last  (s_col_last),
    .s_frame_last(s_frame_last),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_limb      (m_limb),
    .m_col_idx   (m_col_idx),
    .m_frame_last(m_frame_last),
    .m_carry     (m_carry),
    .ovf         (ovf)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  // Record every limb transfer, sampled mid-cycle before the transferring edge.
  always @(negedge ap_clk) begin
    if (ap_rst_n && m_valid && m_ready) begin
      recs.push_back('{limb: m_limb, idx: m_col_idx, fl: m_frame_last, carry: m_carry});
      xfer_cnt++;
    end
  end

  // Present one beat (called #1 after a rising edge); returns #1 after the
  // edge that accepted it, with s_valid dropped.
  task automatic send_beat(input logic [63:0] d, input logic cl, input logic fl);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = d; s_col_last = cl; s_frame_last = fl;
    while (!s_ready && n < 50) begin
      @(posedge ap_clk); #1;
      n++;
    end
    if (!s_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_beat_timeout: s_ready=%0b required 1 within 50 cycles", s_ready);
    end
    @(posedge ap_clk); #1;
    s_valid = 1'b0; s_col_last = 1'b0; s_frame_last = 1'b0; s_data = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ap_clk); #1;
    end
  endtask

  task automatic test_reset;
    ap_rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_col_last = 1'b0;
    s_frame_last = 1'b0; m_ready = 1'b1;
    #3;
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_m_valid: got %0b want 0", m_valid); end
    vectors++; if (m_limb !== 28'h0) begin miscompares++; $display("FAIL rst_m_limb: got %h want 0", m_limb); end
    vectors++; if (m_col_idx !== 5'd0) begin miscompares++; $display("FAIL rst_m_col_idx: got %0d want 0", m_col_idx); end
    vectors++; if (m_frame_last !== 1'b0) begin miscompares++; $display("FAIL rst_m_frame_last: got %0b want 0", m_frame_last); end
    vectors++; if (m_carry !== 52'h0) begin miscompares++; $display("FAIL rst_m_carry: got %h want 0", m_carry); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL rst_ovf: got %0b want 0", ovf); end
    @(posedge ap_clk); @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    #1;
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL rst_s_ready: got %0b want 1", s_ready); end
    idle(1);
  endtask

  task automatic test_single_product;
    send_beat(64'h0000_0000_1234_5678, 1'b1, 1'b1);
    vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %0b want 1", m_valid); end
    vectors++; if (m_limb !== 28'h2345678) begin miscompares++; $display("FAIL single_limb: got %h want 2345678", m_limb); end
    vectors++; if (m_carry !== 52'h1) begin miscompares++; $display("FAIL single_carry: got %h want 1", m_carry); end
    vectors++; if (m_frame_last !== 1'b1) begin miscompares++; $display("FAIL single_frame_last: got %0b want 1", m_frame_last); end
    vectors++; if (m_col_idx !== 5'd0) begin miscompares++; $display("FAIL single_col_idx: got %0d want 0", m_col_idx); end
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL single_s_ready_emit: got %0b want 0", s_ready); end
  endtask

  task automatic test_col_carry;
    send_beat(64'h0FFF_FFFF, 1'b0, 1'b0);
    send_beat(64'h1, 1'b1, 1'b0);
    vectors++; if (m_limb !== 28'h0) begin miscompares++; $display("FAIL carry_col0_limb: got %h want 0", m_limb); end
    vectors++; if (m_col_idx !== 5'd0) begin miscompares++; $display("FAIL carry_col0_idx: got %0d want 0", m_col_idx); end
    vectors++; if (m_frame_last !== 1'b0) begin miscompares++; $display("FAIL carry_col0_fl: got %0b want 0", m_frame_last); end
    vectors++; if (m_carry !== 52'h0) begin miscompares++; $display("FAIL carry_col0_mcarry: got %h want 0", m_carry); end
    send_beat(64'h5, 1'b1, 1'b1);
    vectors++; if (m_limb !== 28'h6) begin miscompares++; $display("FAIL carry_col1_limb: got %h want 6", m_limb); end
    vectors++; if (m_col_idx !== 5'd1) begin miscompares++; $display("FAIL carry_col1_idx: got %0d want 1", m_col_idx); end
    vectors++; if (m_frame_last !== 1'b1) begin miscompares++; $display("FAIL carry_col1_fl: got %0b want 1", m_frame_last); end
    vectors++; if (m_carry !== 52'h0) begin miscompares++; $display("FAIL carry_col1_mcarry: got %h want 0", m_carry); end
  endtask

  task automatic test_backpressure;
    int xc;
    idle(2);
    m_ready = 1'b0;
    send_beat(64'h7, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL bp_s_ready cyc%0d: got %0b want 0", i, s_ready); end
      vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL bp_m_valid cyc%0d: got %0b want 1", i, m_valid); end
      vectors++; if (m_limb !== 28'h7) begin miscompares++; $display("FAIL bp_m_limb cyc%0d: got %h want 7", i, m_limb); end
      vectors++; if (m_frame_last !== 1'b1) begin miscompares++; $display("FAIL bp_m_fl cyc%0d: got %0b want 1", i, m_frame_last); end
      idle(1);
    end
    xc = xfer_cnt;
    m_ready = 1'b1;
    idle(1);
    m_ready = 1'b0;
    vectors++; if (xfer_cnt !== xc + 1) begin miscompares++; $display("FAIL bp_xfer_count: got %0d want %0d", xfer_cnt - xc, 1); end
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL bp_valid_after: got %0b want 0", m_valid); end
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL bp_s_ready_after: got %0b want 1", s_ready); end
    m_ready = 1'b1;
  endtask

  task automatic test_max_terms;
    // 256 * (2^64-1) = 2^72 - 256: limb = 0xFFFFF00, carry = 2^44 - 1
    for (int i = 0; i < 255; i++) send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    vectors++; if (m_limb !== 28'hFFFFF00) begin miscompares++; $display("FAIL max_limb: got %h want FFFFF00", m_limb); end
    vectors++; if (m_carry !== 52'h0_0FFF_FFFF_FFFF) begin miscompares++; $display("FAIL max_carry: got %h want 00FFFFFFFFFFF", m_carry); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL max_ovf_256: got %0b want 0", ovf); end
    // 257 terms: sum = 2^72 + 2^64 - 257, low limb = 0xFFFFEFF
    for (int i = 0; i < 256; i++) send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL max_ovf_before_257: got %0b want 0", ovf); end
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL max_ovf_257: got %0b want 1", ovf); end
    vectors++; if (m_limb !== 28'hFFFFEFF) begin miscompares++; $display("FAIL max_limb_257: got %h want FFFFEFF", m_limb); end
    send_beat(64'h1, 1'b1, 1'b1);
    vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL max_ovf_sticky: got %0b want 1", ovf); end
    vectors++; if (m_limb !== 28'h1) begin miscompares++; $display("FAIL max_after_limb: got %h want 1", m_limb); end
  endtask

  task automatic test_reset_midframe;
    send_beat(64'h1000_0005, 1'b1, 1'b0);
    send_beat(64'h2000_0000, 1'b1, 1'b0);
    vectors++; if (m_limb !== 28'h1) begin miscompares++; $display("FAIL mid_col1_limb: got %h want 1", m_limb); end
    vectors++; if (m_col_idx !== 5'd1) begin miscompares++; $display("FAIL mid_col1_idx: got %0d want 1", m_col_idx); end
    for (int i = 0; i < 3; i++) send_beat(64'h9, 1'b0, 1'b0);
    ap_rst_n = 1'b0;
    #1;
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %0b want 0", m_valid); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ovf: got %0b want 0", ovf); end
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    send_beat(64'h2, 1'b1, 1'b0);
    vectors++; if (m_limb !== 28'h2) begin miscompares++; $display("FAIL mid_new_limb: got %h want 2", m_limb); end
    vectors++; if (m_col_idx !== 5'd0) begin miscompares++; $display("FAIL mid_new_idx: got %0d want 0", m_col_idx); end
    vectors++; if (m_frame_last !== 1'b0) begin miscompares++; $display("FAIL mid_new_fl: got %0b want 0", m_frame_last); end
    send_beat(64'h3, 1'b1, 1'b1);
    vectors++; if (m_limb !== 28'h3) begin miscompares++; $display("FAIL mid_new2_limb: got %h want 3", m_limb); end
    vectors++; if (m_col_idx !== 5'd1) begin miscompares++; $display("FAIL mid_new2_idx: got %0d want 1", m_col_idx); end
  endtask

  task automatic test_back_to_back;
    idle(2);
    recs.delete();
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 16; c++)
        send_beat(64'h1, 1'b1, (c == 15));
    idle(3);
    vectors++; if (recs.size() !== 32) begin miscompares++; $display("FAIL b2b_count: got %0d want 32", recs.size()); end
    for (int i = 0; i < 32; i++) begin
      if (i < recs.size()) begin
        vectors++; if (recs[i].limb !== 28'h1) begin miscompares++; $display("FAIL b2b_limb[%0d]: got %h want 1", i, recs[i].limb); end
        vectors++; if (recs[i].idx !== 5'(i % 16)) begin miscompares++; $display("FAIL b2b_idx[%0d]: got %0d want %0d", i, recs[i].idx, i % 16); end
        vectors++; if (recs[i].fl !== ((i % 16) == 15)) begin miscompares++; $display("FAIL b2b_fl[%0d]: got %0b want %0b", i, recs[i].fl, ((i % 16) == 15)); end
        vectors++; if (recs[i].carry !== 52'h0) begin miscompares++; $display("FAIL b2b_carry[%0d]: got %h want 0", i, recs[i].carry); end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    xfer_cnt = 0;
    test_reset();
    test_single_product();
    test_col_carry();
    test_backpressure();
    test_max_terms();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
